// File: rtl/bin_mem_responder_if.sv
// bin_mem_responder_if: request/response bundle between the compute block and a bank memory responder.
interface bin_mem_responder_if #(
  parameter int ADDR_LEN = 10,
  parameter int DATA_LEN = 1,
  parameter int SEL_LEN  = 2,
  parameter int RW_LEN   = 2
);
  logic [ADDR_LEN-1:0] addr;
  logic [SEL_LEN-1:0]  sel;
  logic [RW_LEN-1:0]   rw;
  logic [DATA_LEN-1:0] wdata;
  logic                err_clr;
  logic [DATA_LEN-1:0] rdata;
  logic                rvalid;
  logic                busy;
  logic                err;
  modport master (output addr, sel, rw, wdata, err_clr, input rdata, rvalid, busy, err);
  modport slave (input addr, sel, rw, wdata, err_clr, output rdata, rvalid, busy, err);
endinterface

// File: rtl/bin_mem_responder.sv
// bin_mem_responder: banked word memory with pipelined reads, writes and a per-bank clear sequence.
// Define MEM_RD_HOLD_EN to hold rdata at the last read value between reads (default: rdata is 0 when not valid).
module bin_mem_responder #(
  parameter int ADDR_LEN = 10,
  parameter int DATA_LEN = 1,
  parameter int SEL_LEN  = 2,
  parameter int RW_LEN   = 2,
  parameter int DEPTH    = 784,
  parameter int READ_LAT = 2
) (
  input logic clk,
  input logic rst,
  bin_mem_responder_if.slave bus
);
  localparam int NB = 1 << SEL_LEN;
`ifdef MEM_RD_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_nx;
  logic [DATA_LEN-1:0] mem [NB][DEPTH];
  logic [ADDR_LEN-1:0] cnt;
  logic [SEL_LEN-1:0] cbank;
  logic [1:0] cmd;
  logic [DATA_LEN-1:0] rd_data;
  logic in_range, last, rd, wr_ok, err_set, busy, err_q;
  assign cmd = bus.rw[1:0];
  assign in_range = 32'(bus.addr) < 32'(DEPTH);
  assign last = 32'(cnt) == 32'(DEPTH - 1);
  assign rd_data = in_range ? mem[bus.sel][bus.addr] : '0;
  always_comb begin
    state_nx = state == IDLE ? (cmd == 2'b11 ? CLEAR : IDLE) : (last ? IDLE : CLEAR);
    busy = state == CLEAR;
    rd = cmd == 2'b01;
    wr_ok = state == IDLE && cmd == 2'b10 && in_range;
    err_set = ((cmd == 2'b01 || cmd == 2'b10) && !in_range) || (state == CLEAR && cmd[1]);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      cbank <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= state == CLEAR ? cnt + 1'b1 : '0;
      cbank <= state == IDLE && cmd == 2'b11 ? bus.sel : cbank;
      err_q <= err_set | (err_q & ~bus.err_clr);
    end
  // Array is never reset; an asserted reset only blocks writes so a clear is cut short where it stands.
  always_ff @(posedge clk or posedge rst)
    if (!rst) begin
      if (state == CLEAR) mem[cbank][cnt] <= '0;
      else if (wr_ok) mem[bus.sel][bus.addr] <= bus.wdata;
    end
  for (genvar s = 0; s < READ_LAT; s++) begin : g_st
    logic v;
    logic [DATA_LEN-1:0] d;
    if (s == 0) begin : g_in
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          v <= 1'b0;
          d <= '0;
        end else begin
          v <= rd;
          d <= rd ? rd_data : (HOLD && READ_LAT == 1) ? d : '0;
        end
    end else begin : g_in
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          v <= 1'b0;
          d <= '0;
        end else begin
          v <= g_st[s-1].v;
          d <= g_st[s-1].v ? g_st[s-1].d : (HOLD && s == READ_LAT - 1) ? d : '0;
        end
    end
  end
  assign bus.rvalid = g_st[READ_LAT-1].v;
  assign bus.rdata = g_st[READ_LAT-1].d;
  assign bus.busy = busy;
  assign bus.err = err_q;
endmodule

// File: tb/tb_bin_mem_responder.sv
// tb_bin_mem_responder: directed vector table plus clear/reset sequences for bin_mem_responder (DEPTH=784, READ_LAT=2).
module tb_bin_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int pass = 0, total = 0, n = 0, last_rd = 0;
`ifdef MEM_RD_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif
  typedef struct {int rw, sel, addr, wd, clr, ev, ed, ee;} vec_t;
  vec_t tbl [35];
  bin_mem_responder_if bus ();
  bin_mem_responder dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end
  function automatic vec_t mk(int rw, int sel, int addr, int wd, int clr, int ev, int ed, int ee);
    mk = '{rw, sel, addr, wd, clr, ev, ed, ee};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input int rw, input int sel, input int addr, input int wd, input int clr);
    bus.rw = 2'(rw);
    bus.sel = 2'(sel);
    bus.addr = 10'(addr);
    bus.wdata = 1'(wd);
    bus.err_clr = 1'(clr);
  endtask
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask
  task automatic rd_chk(input string name, input int sel, input int addr, input int exp);
    drive(1, sel, addr, 0, 0);
    step();
    drive(0, 0, 0, 0, 0);
    step();
    chk({name, "_rvalid"}, bus.rvalid, 1);
    chk({name, "_rdata"}, bus.rdata, exp);
  endtask
  task automatic fill_bank1();
    for (int a = 0; a < 784; a++) begin
      drive(2, 1, a, 1, 0);
      step();
    end
    drive(0, 0, 0, 0, 0);
  endtask
  initial begin
    tbl[0] = mk(2, 2, 5, 1, 0, 0, 0, 0);
    tbl[1] = mk(1, 2, 5, 0, 0, 0, 0, 0);
    tbl[2] = mk(0, 0, 0, 0, 0, 1, 1, 0);
    tbl[3] = mk(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) tbl[4+k] = mk(2, 0, k, int'(k % 2 == 0), 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) tbl[12+k] = mk(1, 0, k, 0, 0, int'(k > 0), int'(k > 0 && (k - 1) % 2 == 0), 0);
    tbl[20] = mk(0, 0, 0, 0, 0, 1, 0, 0);
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 0);
    tbl[22] = mk(2, 0, 784, 1, 0, 0, 0, 1);
    tbl[23] = mk(0, 0, 0, 0, 1, 0, 0, 0);
    tbl[24] = mk(1, 3, 900, 0, 0, 0, 0, 1);
    tbl[25] = mk(0, 0, 0, 0, 1, 1, 0, 0);
    tbl[26] = mk(1, 0, 0, 0, 0, 0, 0, 0);
    tbl[27] = mk(1, 0, 1000, 0, 0, 1, 1, 1);
    tbl[28] = mk(0, 0, 0, 0, 1, 1, 0, 0);
    tbl[29] = mk(0, 0, 0, 0, 0, 0, 0, 0);
    tbl[30] = mk(2, 0, 800, 1, 1, 0, 0, 1);
    tbl[31] = mk(0, 0, 0, 0, 1, 0, 0, 0);
    tbl[32] = mk(1, 2, 5, 0, 0, 0, 0, 0);
    tbl[33] = mk(0, 0, 0, 0, 0, 1, 1, 0);
    tbl[34] = mk(0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.err, 0);
    rst = 1'b0;
    for (int i = 0; i < 35; i++) begin
      drive(tbl[i].rw, tbl[i].sel, tbl[i].addr, tbl[i].wd, tbl[i].clr);
      step();
      chk($sformatf("vec%0d_rvalid", i), bus.rvalid, tbl[i].ev);
      if (tbl[i].ev != 0) begin
        chk($sformatf("vec%0d_rdata", i), bus.rdata, tbl[i].ed);
        last_rd = tbl[i].ed;
      end else chk($sformatf("vec%0d_rdata_idle", i), bus.rdata, HOLD ? last_rd : 0);
      chk($sformatf("vec%0d_err", i), bus.err, tbl[i].ee);
    end
    fill_bank1();
    drive(2, 0, 10, 0, 0);
    step();
    drive(2, 0, 11, 0, 0);
    step();
    drive(3, 1, 0, 0, 0);
    step();
    chk("clr_busy_start", bus.busy, 1);
    n = 0;
    while (bus.busy && n < 2000) begin
      n++;
      drive(n == 5 || n == 784 ? 2 : n == 30 || n == 40 ? 1 : n == 50 ? 3 : 0,
            n == 30 || n == 40 ? 1 : 0,
            n == 5 ? 10 : n == 30 ? 500 : n == 784 ? 11 : 0,
            int'(n == 5 || n == 784), int'(n == 20 || n == 60));
      step();
      if (n == 5) chk("clr_wr_err", bus.err, 1);
      if (n == 20) chk("clr_err_clr", bus.err, 0);
      if (n == 31) chk("clr_rd_uncleared_rvalid", bus.rvalid, 1);
      if (n == 31) chk("clr_rd_uncleared", bus.rdata, 1);
      if (n == 41) chk("clr_rd_cleared", bus.rdata, 0);
      if (n == 50) chk("clr_cmd_err", bus.err, 1);
      if (n == 60) chk("clr_err_clr2", bus.err, 0);
    end
    chk("clr_busy_cycles", n, 784);
    chk("clr_exit_wr_err", bus.err, 1);
    drive(0, 0, 0, 0, 1);
    step();
    chk("err_clr_after", bus.err, 0);
    rd_chk("b1_a0", 1, 0, 0);
    rd_chk("b1_a783", 1, 783, 0);
    rd_chk("b0_a10_dropped", 0, 10, 0);
    rd_chk("b0_a11_dropped", 0, 11, 0);
    for (int k = 0; k < 8; k++) rd_chk($sformatf("b0_a%0d_kept", k), 0, k, int'(k % 2 == 0));
    fill_bank1();
    drive(3, 1, 0, 0, 0);
    step();
    for (int k = 1; k <= 100; k++) begin
      drive(k >= 99 ? 1 : 0, 1, 700, 0, 0);
      step();
    end
    chk("pre_rst_rvalid", bus.rvalid, 1);
    chk("pre_rst_busy", bus.busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_rvalid", bus.rvalid, 0);
    drive(0, 0, 0, 0, 0);
    step();
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("post_rst_rvalid%0d", k), bus.rvalid, 0);
    end
    rd_chk("abort_a0", 1, 0, 0);
    rd_chk("abort_a99", 1, 99, 0);
    rd_chk("abort_a100", 1, 100, 1);
    rd_chk("abort_a783", 1, 783, 1);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/bin_mem_responder.md
# bin_mem_responder

Banked memory responder answering the address/select/read-write request interface driven by the binary-network compute block. It holds weight or activation words in 2**SEL_LEN banks. It serves single-word reads with a fixed pipelined latency and single-word writes. It also runs a multi-cycle bank-clear sequence. One instance sits behind the weight port and one behind the input port.

## Interface
- ADDR_LEN, 10, word address width
- DATA_LEN, 1, word width in bits
- SEL_LEN, 2, bank-select width; bank count = 2**SEL_LEN
- RW_LEN, 2, command width; only the low 2 bits are decoded, upper bits ignored
- DEPTH, 784, words per bank; 1 <= DEPTH <= 2**ADDR_LEN
- READ_LAT, 2, read latency in cycles, >= 1

- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-high reset
- addr  input  ADDR_LEN  word address
- sel  input  SEL_LEN  bank select
- rw  input  RW_LEN  command: 00 idle, 01 read, 10 write, 11 clear bank `sel`
- wdata  input  DATA_LEN  write data
- err_clr  input  1  synchronous clear of `err`
- rdata  output  DATA_LEN  read data
- rvalid  output  1  `rdata` is valid this cycle
- busy  output  1  clear sequence in progress
- err  output  1  sticky error flag

## Operation
- Commands are sampled on every rising edge while not in reset.
- FSM states:
  - IDLE → CLEAR on a sampled rw=11. The edge latches `sel` as the clear bank and zeroes the clear counter.
  - CLEAR writes 0 to word[counter] of the latched bank, one word per cycle, then increments the counter.
  - CLEAR → IDLE on the edge that writes word DEPTH-1.
- Read (01) accepted in IDLE or CLEAR:
  - Issues one pipeline token carrying bank[sel][addr].
  - Pipeline depth is READ_LAT; back-to-back reads every cycle are supported with no bubbles.
  - In CLEAR, a read of the bank being cleared returns the stored value. Words already cleared read 0.
- Write (10) in IDLE: bank[sel][addr] <= wdata at the sampling edge.
- Out-of-range request:
  - addr >= DEPTH on a read or write sets `err`.
  - A read still produces a token, with rdata=0.
  - A write is dropped.
- Write or clear command sampled while in CLEAR:
  - Dropped, sets `err`.
  - This includes the edge on which CLEAR exits.
- `err` is sticky until err_clr=1 is sampled. If a set condition and err_clr occur on the same edge, set wins.
- rw=00 has no effect.

## Timing
- Reset values: rdata=0, rvalid=0, busy=0, err=0, FSM=IDLE, all pipeline tokens cleared.
- Bank contents are not altered by reset.
- Read latency:
  - A read sampled at edge N gives rvalid=1 and rdata valid after edge N+READ_LAT−1 completes, i.e. during cycle N+READ_LAT.
  - READ_LAT=1 gives a registered output one cycle after the request.
- Write then read of the same word on the next edge returns the new data. There is no hazard, because the array is updated at the write edge.
- Clear timing:
  - rw=11 sampled at edge N: busy=1 from edge N through edge N+DEPTH.
  - busy deasserts after edge N+DEPTH, which writes the final word.
  - Total clear takes DEPTH cycles.
- Reset asserted mid-clear aborts the clear. The partially cleared bank is left as is.
- Reset mid-read discards in-flight tokens; no late rvalid appears after reset release.
- Outputs are registered; no combinational path from inputs to outputs.

## Configuration
- MEM_RD_HOLD_EN defined: `rdata` holds the last valid read value while rvalid=0.
- MEM_RD_HOLD_EN undefined: `rdata` is forced to 0 whenever rvalid=0.
- In both builds `rdata` resets to 0.

## Test plan
- Reset, then write 1 to bank 2 addr 5, then read bank 2 addr 5 with READ_LAT=2 → rvalid=1 with rdata=1 exactly 2 cycles after the read edge, and rvalid=0 on all other cycles.
- Eight back-to-back reads of addr 0..7 alternating stored 1/0 → eight consecutive rvalid cycles returning 1,0,1,0,1,0,1,0 in order, with no gaps.
- Fill bank 1 with 1s, then issue rw=11 sel=1 with DEPTH=784:
  - busy is high for exactly 784 cycles.
  - After busy falls, reads of addr 0 and addr 783 return 0.
  - Bank 0 is unchanged.
- Write during clear, and write addr=784 → err=1, target word unchanged. err_clr pulse → err=0 on the next edge.
- Reset asserted while clear is at counter 100, with two reads in flight:
  - busy=0 and rvalid=0 immediately.
  - Words 0..99 read 0 and word 100 onward retain 1.
- With MEM_RD_HOLD_EN undefined, rdata=0 between reads; with it defined, rdata holds the last value (1) between reads.
